// File: rtl/irrigation_scheduler_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | irrigation_scheduler_if - sensor/request inputs and valve/alarm outputs   |
// | Rev 1.0                                                                    |
// +--------------------------------------------------------------------------+
interface irrigation_scheduler_if;
  logic       h;
  logic       m;
  logic       l;
  logic [1:0] req;
  logic       clr_err;
  logic       ve;
  logic       al;
  logic [1:0] vz;
  logic       busy;
  logic       err;

  modport master (
    output h, m, l, req, clr_err,
    input  ve, al, vz, busy, err
  );

  modport slave (
    input  h, m, l, req, clr_err,
    output ve, al, vz, busy, err
  );
endinterface
`default_nettype wire

// File: rtl/irrigation_scheduler.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | irrigation_scheduler - debounced tank fill control with two-zone RR slots |
// | Rev 1.0                                                                    |
// +--------------------------------------------------------------------------+
module irrigation_scheduler #(
  parameter int DEB_CYCLES = 4,
  parameter int IRR_CYCLES = 16,
  parameter int GAP_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  irrigation_scheduler_if.slave bus
);

  localparam int              DW       = $clog2(DEB_CYCLES + 1);
  localparam logic [DW-1:0]   DEB_MAX  = DW'(DEB_CYCLES);
  localparam int              CNT_TOP  = (IRR_CYCLES > GAP_CYCLES) ? IRR_CYCLES : GAP_CYCLES;
  localparam int              CW       = $clog2(CNT_TOP + 1);
  localparam logic [CW-1:0]   IRR_LAST = CW'(IRR_CYCLES - 1);
  localparam logic [CW-1:0]   GAP_LAST = CW'(GAP_CYCLES - 1);

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_IRRIGATE = 2'd1;
  localparam logic [1:0] ST_GAP      = 2'd2;
  localparam logic [1:0] ST_FAULT    = 2'd3;

  logic [2:0] raw;
  logic [2:0] filt;
  assign raw = {bus.h, bus.m, bus.l};

  // The filtered bit flips on the (DEB_CYCLES+1)-th consecutive differing synced sample.
  for (genvar i = 0; i < 3; i++) begin : g_sensor
    logic          sync_a;
    logic          sync_b;
    logic          filt_q;
    logic [DW-1:0] deb_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        sync_a  <= 1'b0;
        sync_b  <= 1'b0;
        filt_q  <= 1'b0;
        deb_cnt <= '0;
      end else begin
        sync_a <= raw[i];
        sync_b <= sync_a;
        if (sync_b == filt_q) begin
          deb_cnt <= '0;
        end else if (deb_cnt == DEB_MAX) begin
          filt_q  <= sync_b;
          deb_cnt <= '0;
        end else begin
          deb_cnt <= deb_cnt + 1'b1;
        end
      end
    end

    assign filt[i] = filt_q;
  end

  logic lvl_empty;
  logic lvl_low;
  logic lvl_full;
  logic lvl_invalid;

  always_comb begin
    lvl_empty   = 1'b0;
    lvl_low     = 1'b0;
    lvl_full    = 1'b0;
    lvl_invalid = 1'b0;
    case (filt)
      3'b000:  lvl_empty   = 1'b1;
      3'b001:  lvl_low     = 1'b1;
      3'b011:  ;
      3'b111:  lvl_full    = 1'b1;
      default: lvl_invalid = 1'b1;
    endcase
  end

  logic [1:0]    state;
  logic [1:0]    state_n;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_n;
  logic [1:0]    grant;
  logic [1:0]    grant_n;
  logic          last;
  logic          last_n;
  logic          ve_q;
  logic          ve_n;
  logic          al_q;
  logic          al_n;
  logic          busy_q;
  logic          err_q;

  logic          grant_ok;
  logic          pick_idx;
  logic [1:0]    pick_oh;

  assign grant_ok = (bus.req != 2'b00) && !lvl_empty && !lvl_invalid;
  assign pick_idx = (bus.req == 2'b11) ? ~last : bus.req[1];
  assign pick_oh  = pick_idx ? 2'b10 : 2'b01;

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    grant_n = grant;
    last_n  = last;
    if (lvl_invalid) begin
      state_n = ST_FAULT;
      cnt_n   = '0;
      grant_n = 2'b00;
    end else begin
      case (state)
        ST_IDLE: begin
          if (grant_ok) begin
            state_n = ST_IRRIGATE;
            cnt_n   = '0;
            grant_n = pick_oh;
            last_n  = pick_idx;
          end
        end
        ST_IRRIGATE: begin
          if (cnt == IRR_LAST || (bus.req & grant) == 2'b00 || lvl_empty) begin
            state_n = ST_GAP;
            cnt_n   = '0;
            grant_n = 2'b00;
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end
        ST_GAP: begin
          // Last gap cycle doubles as the arbitration cycle so the gap is exactly GAP_CYCLES.
          if (cnt == GAP_LAST) begin
            cnt_n = '0;
            if (grant_ok) begin
              state_n = ST_IRRIGATE;
              grant_n = pick_oh;
              last_n  = pick_idx;
            end else begin
              state_n = ST_IDLE;
            end
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end
        default: begin
          if (bus.clr_err) begin
            state_n = ST_IDLE;
            cnt_n   = '0;
            grant_n = 2'b00;
          end
        end
      endcase
    end
  end

  always_comb begin
    al_n = (state_n == ST_FAULT) || lvl_empty || lvl_low;
    if (state_n == ST_FAULT) begin
      ve_n = 1'b0;
    end else if (lvl_empty || lvl_low) begin
      ve_n = 1'b1;
    end else if (lvl_full) begin
      ve_n = 1'b0;
    end else begin
      ve_n = ve_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      grant  <= 2'b00;
      last   <= 1'b1;
      ve_q   <= 1'b0;
      al_q   <= 1'b0;
      busy_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      grant  <= grant_n;
      last   <= last_n;
      ve_q   <= ve_n;
      al_q   <= al_n;
      busy_q <= (state_n == ST_IRRIGATE);
      err_q  <= (state_n == ST_FAULT);
    end
  end

  assign bus.ve   = ve_q;
  assign bus.al   = al_q;
  assign bus.vz   = grant;
  assign bus.busy = busy_q;
  assign bus.err  = err_q;

endmodule
`default_nettype wire
